instr_display_scan: RTL

INSTR_DISPLAY_SCAN -- requirements
Module: instr_display_scan

---
 rtl/instr_display_scan.sv | 110 +++++++++++
 1 files changed

// File: rtl/instr_display_scan.sv
// Eight-digit multiplexed 7-segment scanner for a captured 32-bit instruction word.
// Optional leading-zero blanking is enabled by defining DISP_LZ_BLANK_EN.
module instr_display_scan #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        load,
  input  logic        freeze,
  output logic [31:0] shown,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        frame
);

  localparam int unsigned    CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [31:0]   shown_q, shown_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_q, frame_d;
  logic [3:0]    nibble;

  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    case (n)
      4'h0:    seg_enc = 7'b1000000;
      4'h1:    seg_enc = 7'b1111001;
      4'h2:    seg_enc = 7'b0100100;
      4'h3:    seg_enc = 7'b0110000;
      4'h4:    seg_enc = 7'b0011001;
      4'h5:    seg_enc = 7'b0010010;
      4'h6:    seg_enc = 7'b0000010;
      4'h7:    seg_enc = 7'b1111000;
      4'h8:    seg_enc = 7'b0000000;
      4'h9:    seg_enc = 7'b0011000;
      4'hA:    seg_enc = 7'b0001000;
      4'hB:    seg_enc = 7'b0000011;
      4'hC:    seg_enc = 7'b1000110;
      4'hD:    seg_enc = 7'b0100001;
      4'hE:    seg_enc = 7'b0000110;
      default: seg_enc = 7'b0001110;
    endcase
  endfunction

  // Capture and scan advance are independent; freeze always beats load.
  always_comb begin
    shown_d = shown_q;
    if (load && !freeze) shown_d = instr;
  end

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  assign nibble = shown_q[{idx_q, 2'b00} +: 4];

`ifdef DISP_LZ_BLANK_EN
  logic [2:0] msd;

  always_comb begin
    msd = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (shown_q[4*k +: 4] != 4'h0) msd = 3'(k);
    end
  end
`endif

  // Slot with cnt==0 is blanked so the old digit never ghosts onto the new anode.
  always_comb begin
    an_d    = (cnt_q == '0) ? 8'hFF : ~(8'b1 << idx_q);
    seg_d   = seg_enc(nibble);
`ifdef DISP_LZ_BLANK_EN
    if (idx_q > msd) seg_d = 7'b1111111;
`endif
    frame_d = (idx_q == 3'd7) && (cnt_q == CNT_MAX);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shown_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= 8'hFF;
      seg_q   <= 7'b1111111;
      frame_q <= 1'b0;
    end else begin
      shown_q <= shown_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

  assign shown = shown_q;
  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule
